gpu_prefetch: RTL and testbench
===============================

Name: gpu_prefetch

Overview:
- Instruction prefetch queue for the GPU execution unit.
- Fetches 32-bit longs from local RAM and splits each into two 16-bit instruction halfwords, big-endian: the high halfword is the lower address.
- Buffers the halfwords in a small FIFO and presents the head halfword with insrdy to the downstream execution controller, which pops it with a romold pulse.
- Jumps flush the queue and restart fetching at the new address, including mid-long (odd-halfword) targets.

Parameters:
- DEPTH, 4, queue depth in halfwords; power of two, ≥4.
- AW, 24, byte address width.

Ports:
- clk_0  in  1  single system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- go  in  1  GPU running; 0 inhibits new fetch requests.
- jump_go  in  1  one-cycle flush-and-redirect strobe.
- jump_addr  in  AW  jump target byte address; bit 0 ignored.
- romold  in  1  downstream consumes head halfword this cycle.
- pfreq  out  1  long fetch request.
- pfaddr  out  AW-2  long address of request.
- pfack  in  1  fetch complete; pfdata valid this cycle.
- pfdata  in  32  fetched long.
- insrdy  out  1  queue non-empty.
- instr  out  16  head halfword; valid when insrdy=1.
- ins_pc  out  AW  byte address of head halfword; bit 0 always 0.

Behaviour:
- Reset (async):
  - count=0, rd/wr pointers=0, insrdy=0, pfreq=0, pfaddr=0, ins_pc=0.
  - skip=0, outstanding=0, instr=0.
- State:
  - fa: next long address.
  - count: 0..DEPTH.
  - outstanding: request open.
  - skip: discard the high halfword of the next delivered long.
- Request rule:
  - pfreq is registered.
  - pfreq rises in the cycle after the condition (go=1, no jump_go, outstanding=0, DEPTH-count ≥ 2) holds.
  - pfaddr=fa while pfreq=1.
  - pfreq is held high, with pfaddr stable, until pfack.
  - pfack may arrive in the first cycle pfreq is high.
  - pfack with pfreq=0 is ignored.
- Ack:
  - Deassert pfreq next cycle; fa increments by 1, wrapping modulo 2^(AW-2).
  - skip=0: write pfdata[31:16] then pfdata[15:0]; count+=2.
  - skip=1: write only pfdata[15:0]; count+=1; clear skip.
  - New entries are visible the next cycle; there is no bypass.
- Pop:
  - romold with insrdy=1: rd pointer+1, count-1, ins_pc+=2 (wrap modulo 2^AW).
  - romold with insrdy=0 is ignored; no underflow and no ins_pc change.
- Simultaneous ack and pop: count = count + n - 1, where n is 1 or 2.
- Full-space rule guarantees no overflow: a request is only issued with at least 2 free entries, and pops only free space.
- jump_go (highest priority, overrides ack and pop in the same cycle):
  - Next cycle: count=0, pointers=0, insrdy=0, pfreq=0, outstanding=0.
  - fa=jump_addr[AW-1:2]; skip=jump_addr[1]; ins_pc={jump_addr[AW-1:1],0}.
  - An ack coinciding with jump_go is discarded.
  - A pending unacknowledged request is abandoned.
- go=0:
  - No new requests; an open request stays asserted until acked and its data is queued.
  - Queue contents are retained and pops continue.
- Latency:
  - jump_go at cycle N → pfreq at N+1.
  - With zero-wait ack at N+1, insrdy=1 at N+2.
- Wrap-around: FIFO pointers wrap modulo DEPTH; fa wraps silently.

Decomposition:
- Shared package gpu_pkg:
  - PF_DEPTH default.
  - halfword_t (16-bit).
  - long address type (AW-2 bits).
- One sub-module, gpu_prefetch_fifo: DEPTH×16 register-file FIFO.
  - Accepts 0/1/2 writes per cycle (two write enables, ordered) and one read per cycle.
  - Has a synchronous clear input and outputs count.
  - Control, address and skip logic stay in the parent.

Test Plan:
- Cold start: reset, go=1, jump_go with jump_addr=0x00F03000, zero-wait pfack, pfdata=0x98001234:
  - pfreq at N+1, pfaddr=0x3C0C00.
  - instr=0x9800, ins_pc=0xF03000 at N+2.
  - After one romold: instr=0x1234, ins_pc=0xF03002.
- Misaligned jump: jump_addr=0x00F03006, pfdata=0xAAAABBBB:
  - Only 0xBBBB queued, ins_pc=0xF03006, count=1.
  - Next pfaddr=0x3C0C02.
- Back-pressure: never pop, ack every request:
  - Exactly two longs fetched (count=4).
  - pfreq stays 0 until one pop leaves 3 entries, then still 0.
  - After a second pop, pfreq reasserts.
- Flush collision: pfreq high, assert jump_go in the same cycle as pfack and romold:
  - Ack data discarded, queue empty, ins_pc=new target.
  - Next request uses the new fa.
- Wait states plus go drop: hold pfack low 5 cycles, deassert go during the wait:
  - pfreq and pfaddr stay stable until ack.
  - Data is queued; no further request while go=0.
- Pop on empty and async reset mid-request:
  - romold with insrdy=0 leaves ins_pc unchanged.
  - reset_n low mid-request immediately clears pfreq and insrdy.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types and defaults for the GPU instruction prefetch path.
package gpu_pkg;

  localparam int unsigned PF_DEPTH = 4;
  localparam int unsigned PF_AW    = 24;

  typedef logic [15:0]       halfword_t;
  typedef logic [PF_AW-3:0]  long_addr_t;

endpackage

// File: rtl/gpu_prefetch_fifo.sv
// DEPTH x 16 register-file FIFO: up to two ordered writes and one read per cycle.
module gpu_prefetch_fifo
  import gpu_pkg::*;
#(
  parameter int unsigned DEPTH = PF_DEPTH
) (
  input  logic                       clk_0,
  input  logic                       reset_n,
  input  logic                       clr,
  input  logic                       we0,
  input  halfword_t                  wd0,
  input  logic                       we1,
  input  halfword_t                  wd1,
  input  logic                       re,
  output halfword_t                  rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  halfword_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr1_ptr_c;
  logic            rd_ok_c;

  // Second write lands after the first when both are enabled.
  assign wr1_ptr_c = wr_ptr + PW'(we0);
  assign rd_ok_c   = re & (count != '0);
  assign rdata     = mem[rd_ptr];

  always_ff @(posedge clk_0 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (we0) mem[wr_ptr]    <= wd0;
      if (we1) mem[wr1_ptr_c] <= wd1;
      wr_ptr <= wr_ptr + PW'(we0) + PW'(we1);
      rd_ptr <= rd_ptr + PW'(rd_ok_c);
      count  <= count + CW'(we0) + CW'(we1) - CW'(rd_ok_c);
    end
  end

endmodule

// File: rtl/gpu_prefetch.sv
// Instruction prefetch queue: fetches longs, splits them big-endian into halfwords,
// and hands them to the execution controller; jumps flush and redirect fetching.
module gpu_prefetch
  import gpu_pkg::*;
#(
  parameter int unsigned DEPTH = PF_DEPTH,
  parameter int unsigned AW    = PF_AW
) (
  input  logic            clk_0,
  input  logic            reset_n,
  input  logic            go,
  input  logic            jump_go,
  input  logic [AW-1:0]   jump_addr,
  input  logic            romold,
  output logic            pfreq,
  output logic [AW-3:0]   pfaddr,
  input  logic            pfack,
  input  logic [31:0]     pfdata,
  output logic            insrdy,
  output halfword_t       instr,
  output logic [AW-1:0]   ins_pc
);

  localparam int unsigned LW = AW - 2;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [LW-1:0]  fa;
  logic           skip;
  logic           outstanding;
  logic [CW-1:0]  count;
  logic           ack_c;
  logic           pop_c;
  logic           req_c;
  logic           we1_c;
  halfword_t      wd0_c;
  logic           addr_lsb_unused;

  // The request register doubles as the open-request flag.
  assign outstanding     = pfreq;
  assign addr_lsb_unused = jump_addr[0];

  assign ack_c  = pfack & pfreq & ~jump_go;
  assign pop_c  = romold & insrdy & ~jump_go;
  assign req_c  = go & ~jump_go & ~outstanding & (count <= CW'(DEPTH - 2));
  assign we1_c  = ack_c & ~skip;
  assign wd0_c  = skip ? pfdata[15:0] : pfdata[31:16];
  assign insrdy = (count != '0);

  gpu_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_0   (clk_0),
    .reset_n (reset_n),
    .clr     (jump_go),
    .we0     (ack_c),
    .wd0     (wd0_c),
    .we1     (we1_c),
    .wd1     (pfdata[15:0]),
    .re      (pop_c),
    .rdata   (instr),
    .count   (count)
  );

  // A jump restarts fetching straight away so the first long is requested next cycle.
  always_ff @(posedge clk_0 or negedge reset_n) begin
    if (!reset_n) begin
      pfreq  <= 1'b0;
      pfaddr <= '0;
      fa     <= '0;
      skip   <= 1'b0;
      ins_pc <= '0;
    end else if (jump_go) begin
      fa     <= jump_addr[AW-1:2];
      skip   <= jump_addr[1];
      ins_pc <= {jump_addr[AW-1:1], 1'b0};
      pfreq  <= go;
      pfaddr <= jump_addr[AW-1:2];
    end else begin
      if (ack_c) begin
        pfreq <= 1'b0;
        fa    <= fa + LW'(1);
        skip  <= 1'b0;
      end else if (req_c) begin
        pfreq  <= 1'b1;
        pfaddr <= fa;
      end
      if (pop_c) ins_pc <= ins_pc + AW'(2);
    end
  end

endmodule

// File: tb/tb_gpu_prefetch.sv
// Self-checking bench for gpu_prefetch: directed table, corner sequences, random vs queue model.
module tb_gpu_prefetch;

  localparam int unsigned DEPTH = 4;

  logic        clk_0 = 1'b0;
  logic        reset_n;
  logic        go, jump_go, romold, pfack;
  logic [23:0] jump_addr;
  logic [31:0] pfdata;
  logic        pfreq, insrdy;
  logic [21:0] pfaddr;
  logic [15:0] instr;
  logic [23:0] ins_pc;

  int vectors = 0;
  int miscompares = 0;

  gpu_prefetch #(.DEPTH(DEPTH), .AW(24)) dut (
    .clk_0(clk_0), .reset_n(reset_n), .go(go), .jump_go(jump_go),
    .jump_addr(jump_addr), .romold(romold), .pfreq(pfreq), .pfaddr(pfaddr),
    .pfack(pfack), .pfdata(pfdata), .insrdy(insrdy), .instr(instr), .ins_pc(ins_pc)
  );

  always #5 clk_0 = ~clk_0;

  // Behavioural model: a halfword queue plus the fetch pointer and one open request.
  logic [15:0] hq[$];
  logic [21:0] m_fa, m_raddr;
  logic [23:0] m_pc;
  bit          m_skip, m_req;

  task automatic m_reset();
    hq.delete();
    m_fa = '0; m_raddr = '0; m_pc = '0; m_skip = 0; m_req = 0;
  endtask

  task automatic m_step();
    bit can_req;
    if (jump_go) begin
      hq.delete();
      m_fa   = jump_addr[23:2];
      m_skip = jump_addr[1];
      m_pc   = {jump_addr[23:1], 1'b0};
      m_req  = go;
      m_raddr = m_fa;
    end else begin
      can_req = go && !m_req && (int'(DEPTH) - hq.size() >= 2);
      if (romold && hq.size() > 0) begin
        void'(hq.pop_front());
        m_pc = m_pc + 24'd2;
      end
      if (pfack && m_req) begin
        if (!m_skip) hq.push_back(pfdata[31:16]);
        hq.push_back(pfdata[15:0]);
        m_skip = 0;
        m_fa   = m_fa + 22'd1;
        m_req  = 0;
      end else if (can_req) begin
        m_req   = 1;
        m_raddr = m_fa;
      end
    end
  endtask

  task automatic mcheck(input string tag);
    bit bad;
    logic [15:0] e_instr;
    e_instr = (hq.size() > 0) ? hq[0] : 16'h0;
    bad = (pfreq !== m_req) || (m_req && pfaddr !== m_raddr) ||
          (insrdy !== (hq.size() > 0)) || ((hq.size() > 0) && instr !== e_instr) ||
          (ins_pc !== m_pc);
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL model %s: got pfreq=%0b pfaddr=%h insrdy=%0b instr=%h ins_pc=%h, expected pfreq=%0b pfaddr=%h insrdy=%0b instr=%h ins_pc=%h",
               tag, pfreq, pfaddr, insrdy, instr, ins_pc, m_req, m_raddr, hq.size() > 0, e_instr, m_pc);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, clock the DUT, compare.
  task automatic cyc(input bit g, input bit j, input logic [23:0] ja, input bit rm,
                     input bit ak, input logic [31:0] d, input string tag);
    go = g; jump_go = j; jump_addr = ja; romold = rm; pfack = ak; pfdata = d;
    m_step();
    @(posedge clk_0); #1;
    mcheck(tag);
  endtask

  typedef struct {
    bit go, jmp; logic [23:0] ja; bit rm, ack; logic [31:0] d;
    bit e_req; logic [21:0] e_addr; bit e_rdy; logic [15:0] e_instr; logic [23:0] e_pc;
  } vec_t;

  function automatic vec_t mk(bit g, bit j, logic [23:0] ja, bit rm, bit ak, logic [31:0] d,
                              bit er, logic [21:0] ea, bit ey, logic [15:0] ei, logic [23:0] ep);
    vec_t v;
    v.go = g; v.jmp = j; v.ja = ja; v.rm = rm; v.ack = ak; v.d = d;
    v.e_req = er; v.e_addr = ea; v.e_rdy = ey; v.e_instr = ei; v.e_pc = ep;
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    tbl[0]  = mk(1,1,24'hF03000,0,0,32'h0,        1,22'h3C0C00,0,16'h0000,24'hF03000);
    tbl[1]  = mk(1,0,24'h0,     0,1,32'h98001234, 0,22'h0,     1,16'h9800,24'hF03000);
    tbl[2]  = mk(1,0,24'h0,     1,0,32'h0,        1,22'h3C0C01,1,16'h1234,24'hF03002);
    tbl[3]  = mk(1,1,24'hF03006,0,0,32'h0,        1,22'h3C0C01,0,16'h0000,24'hF03006);
    tbl[4]  = mk(1,0,24'h0,     0,1,32'hAAAABBBB, 0,22'h0,     1,16'hBBBB,24'hF03006);
    tbl[5]  = mk(1,0,24'h0,     0,0,32'h0,        1,22'h3C0C02,1,16'hBBBB,24'hF03006);
    tbl[6]  = mk(1,0,24'h0,     1,1,32'h11112222, 0,22'h0,     1,16'h1111,24'hF03008);
    tbl[7]  = mk(1,0,24'h0,     0,0,32'h0,        1,22'h3C0C03,1,16'h1111,24'hF03008);
    tbl[8]  = mk(1,1,24'h000100,0,0,32'h0,        1,22'h000040,0,16'h0000,24'h000100);
    tbl[9]  = mk(1,0,24'h0,     0,1,32'h01020304, 0,22'h0,     1,16'h0102,24'h000100);
    tbl[10] = mk(1,0,24'h0,     0,0,32'h0,        1,22'h000041,1,16'h0102,24'h000100);
    tbl[11] = mk(1,0,24'h0,     0,1,32'h05060708, 0,22'h0,     1,16'h0102,24'h000100);
    tbl[12] = mk(1,0,24'h0,     0,0,32'h0,        0,22'h0,     1,16'h0102,24'h000100);
    tbl[13] = mk(1,0,24'h0,     1,0,32'h0,        0,22'h0,     1,16'h0304,24'h000102);
    tbl[14] = mk(1,0,24'h0,     0,0,32'h0,        0,22'h0,     1,16'h0304,24'h000102);
    tbl[15] = mk(1,0,24'h0,     1,0,32'h0,        0,22'h0,     1,16'h0506,24'h000104);
    tbl[16] = mk(1,0,24'h0,     0,0,32'h0,        1,22'h000042,1,16'h0506,24'h000104);
    tbl[17] = mk(1,0,24'h0,     0,0,32'h0,        1,22'h000042,1,16'h0506,24'h000104);

    reset_n = 1'b0; go = 0; jump_go = 0; jump_addr = '0; romold = 0; pfack = 0; pfdata = '0;
    m_reset();
    repeat (2) @(posedge clk_0);
    #1;
    chk("reset pfreq", 32'(pfreq), 32'h0);
    chk("reset pfaddr", 32'(pfaddr), 32'h0);
    chk("reset insrdy", 32'(insrdy), 32'h0);
    chk("reset instr", 32'(instr), 32'h0);
    chk("reset ins_pc", 32'(ins_pc), 32'h0);
    reset_n = 1'b1;
    cyc(0,0,24'h0,0,0,32'h0,"idle go=0");

    // Directed table: cold start, misaligned jump, back-pressure.
    for (int i = 0; i < 18; i++) begin
      bit bad;
      cyc(tbl[i].go, tbl[i].jmp, tbl[i].ja, tbl[i].rm, tbl[i].ack, tbl[i].d, $sformatf("row%0d", i));
      bad = (pfreq !== tbl[i].e_req) || (tbl[i].e_req && pfaddr !== tbl[i].e_addr) ||
            (insrdy !== tbl[i].e_rdy) || (tbl[i].e_rdy && instr !== tbl[i].e_instr) ||
            (ins_pc !== tbl[i].e_pc);
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL table row%0d: got pfreq=%0b pfaddr=%h insrdy=%0b instr=%h ins_pc=%h, expected pfreq=%0b pfaddr=%h insrdy=%0b instr=%h ins_pc=%h",
                 i, pfreq, pfaddr, insrdy, instr, ins_pc,
                 tbl[i].e_req, tbl[i].e_addr, tbl[i].e_rdy, tbl[i].e_instr, tbl[i].e_pc);
      end
    end

    // Flush collision: jump, ack and pop all in one cycle.
    cyc(1,1,24'h002000,0,0,32'h0,"fc jump");
    cyc(1,0,24'h0,0,1,32'h11112222,"fc ack");
    cyc(1,0,24'h0,0,0,32'h0,"fc req");
    chk("fc pending pfaddr", 32'(pfaddr), 32'h801);
    cyc(1,1,24'h004002,1,1,32'hDEADBEEF,"fc collide");
    chk("fc insrdy", 32'(insrdy), 32'h0);
    chk("fc ins_pc", 32'(ins_pc), 32'h004002);
    chk("fc pfreq", 32'(pfreq), 32'h1);
    chk("fc pfaddr", 32'(pfaddr), 32'h1000);

    // Wait states with go dropped mid-wait.
    for (int i = 0; i < 5; i++) begin
      cyc((i < 2), 0, 24'h0, 0, 0, 32'h0, "ws wait");
      chk("ws pfreq held", 32'(pfreq), 32'h1);
      chk("ws pfaddr held", 32'(pfaddr), 32'h1000);
    end
    cyc(0,0,24'h0,0,1,32'hCAFEF00D,"ws ack");
    chk("ws instr", 32'(instr), 32'h0000F00D);
    chk("ws insrdy", 32'(insrdy), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc(0,0,24'h0,0,0,32'h0,"ws go0");
      chk("ws no req", 32'(pfreq), 32'h0);
    end

    // Pop on empty.
    cyc(0,0,24'h0,1,0,32'h0,"pe pop");
    chk("pe pc after pop", 32'(ins_pc), 32'h004004);
    cyc(0,0,24'h0,1,0,32'h0,"pe pop empty");
    chk("pe pc unchanged", 32'(ins_pc), 32'h004004);
    chk("pe insrdy", 32'(insrdy), 32'h0);

    // Async reset while a request is open and data is queued.
    cyc(1,0,24'h0,0,0,32'h0,"ar req");
    cyc(1,0,24'h0,0,1,32'h12345678,"ar ack");
    cyc(1,0,24'h0,0,0,32'h0,"ar req2");
    chk("ar pfreq before", 32'(pfreq), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar pfreq cleared", 32'(pfreq), 32'h0);
    chk("ar insrdy cleared", 32'(insrdy), 32'h0);
    chk("ar ins_pc cleared", 32'(ins_pc), 32'h0);
    m_reset();
    go = 0; pfack = 0; romold = 0; jump_go = 0;
    @(negedge clk_0);
    reset_n = 1'b1;
    cyc(0,0,24'h0,0,0,32'h0,"ar after");

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 8) != 0, ($urandom % 40) == 0, 24'($urandom), 1'($urandom),
          ($urandom % 3) == 0, $urandom, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
